// File: rtl/div_unit_controller.sv
// div_unit_controller: sequences one DIV/DIVU/REM/REMU request through the registered divider core.
// Define DIV_UNIT_REUSE_EN to keep the last core result and answer repeated operands without the core.
module div_unit_controller #(
  parameter int C_WIDTH = 32,
  parameter int ID_W    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               issue_valid,
  output logic               issue_ready,
  input  logic [1:0]         issue_op,
  input  logic [C_WIDTH-1:0] issue_rs1,
  input  logic [C_WIDTH-1:0] issue_rs2,
  input  logic [ID_W-1:0]    issue_id,
  output logic               core_start,
  output logic               core_ack,
  output logic [C_WIDTH-1:0] core_A,
  output logic [C_WIDTH-1:0] core_B,
  input  logic [C_WIDTH-1:0] core_Q,
  input  logic [C_WIDTH-1:0] core_R,
  input  logic               core_complete,
  input  logic               core_B_is_zero,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [C_WIDTH-1:0] wb_data,
  output logic [ID_W-1:0]    wb_id,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  // Handshakes (issue, writeback): a transfer happens on the rising edge where valid && ready are
  // both high; the sender holds valid and payload stable until that edge.
  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_WAIT, ST_WB} state_t;

  localparam logic [C_WIDTH-1:0] ONE = {{(C_WIDTH-1){1'b0}}, 1'b1};

  state_t state, state_next;

  logic               issue_signed;
  logic               rs1_neg, rs2_neg;
  logic [C_WIDTH-1:0] mag_a, mag_b;
  logic               div_zero;
  logic               reuse_hit;
  logic [C_WIDTH-1:0] early_result;
  logic               neg_q, neg_r, rem_op;
  logic [C_WIDTH-1:0] q_fix, r_fix, core_result;

  assign issue_signed = ~issue_op[0];
  assign rs1_neg      = issue_signed & issue_rs1[C_WIDTH-1];
  assign rs2_neg      = issue_signed & issue_rs2[C_WIDTH-1];
  assign mag_a        = rs1_neg ? (~issue_rs1 + ONE) : issue_rs1;
  assign mag_b        = rs2_neg ? (~issue_rs2 + ONE) : issue_rs2;
  assign div_zero     = (issue_rs2 == '0);

  assign q_fix        = neg_q ? (~core_Q + ONE) : core_Q;
  assign r_fix        = neg_r ? (~core_R + ONE) : core_R;
  assign core_result  = rem_op ? r_fix : q_fix;

`ifdef DIV_UNIT_REUSE_EN
  logic               reuse_valid, reuse_signed, op_signed;
  logic [C_WIDTH-1:0] reuse_rs1, reuse_rs2, reuse_q, reuse_r, op_rs1, op_rs2;

  assign reuse_hit = reuse_valid && !div_zero && (reuse_rs1 == issue_rs1) &&
                     (reuse_rs2 == issue_rs2) && (reuse_signed == issue_signed);

  // Raw operands of the request in flight are kept so the store can be keyed on them at completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reuse_valid  <= 1'b0;
      reuse_signed <= 1'b0;
      reuse_rs1    <= '0;
      reuse_rs2    <= '0;
      reuse_q      <= '0;
      reuse_r      <= '0;
      op_signed    <= 1'b0;
      op_rs1       <= '0;
      op_rs2       <= '0;
    end else begin
      if (state == ST_IDLE && issue_valid) begin
        op_signed <= issue_signed;
        op_rs1    <= issue_rs1;
        op_rs2    <= issue_rs2;
      end
      if (core_ack) begin
        reuse_valid  <= 1'b1;
        reuse_signed <= op_signed;
        reuse_rs1    <= op_rs1;
        reuse_rs2    <= op_rs2;
        reuse_q      <= q_fix;
        reuse_r      <= r_fix;
      end
    end
  end
`else
  assign reuse_hit = 1'b0;
`endif

  always_comb begin
    early_result = issue_op[1] ? issue_rs1 : '1;
`ifdef DIV_UNIT_REUSE_EN
    if (!div_zero) early_result = issue_op[1] ? reuse_r : reuse_q;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (issue_valid) state_next = (div_zero || reuse_hit) ? ST_WB : ST_START;
      ST_START: state_next = ST_WAIT;
      ST_WAIT:  if (core_complete) state_next = ST_WB;
      ST_WB:    if (wb_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  assign issue_ready = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign core_start  = (state == ST_START);
  assign core_ack    = (state == ST_WAIT) && core_complete;
  assign wb_valid    = (state == ST_WB);
  assign dbg_state   = state;

  // Magnitudes stay registered from accept through WAIT so the core sees stable operands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_A  <= '0;
      core_B  <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      rem_op  <= 1'b0;
      wb_data <= '0;
      wb_id   <= '0;
    end else begin
      if (state == ST_IDLE && issue_valid) begin
        core_A <= mag_a;
        core_B <= mag_b;
        neg_q  <= rs1_neg ^ rs2_neg;
        neg_r  <= rs1_neg;
        rem_op <= issue_op[1];
        wb_id  <= issue_id;
        if (div_zero || reuse_hit) wb_data <= early_result;
      end
      if (core_ack) wb_data <= core_result;
    end
  end

  // A zero divisor is resolved before the core, so the core flagging one while we wait is a bug.
  a_no_core_zero_divisor: assert property (@(posedge clk) disable iff (!rst)
    !(state == ST_WAIT && core_B_is_zero));

endmodule
